// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result stage: condition evaluation, flag register and two-entry skid buffer
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   in_valid / in_ready        upstream handshake (in_ready is registered)
//   in_result, in_flags        ALU result and {N,Z,C,V} flags
//   in_set_flags, in_cond      flag-update request and condition code
//   in_rd, in_wr_en            destination register and write enable
//   flush                      drop buffered and same-cycle entries
//   out_valid / out_ready      downstream handshake
//   out_result, out_rd, out_wr_en  presented entry (zero when out_valid=0)
//   flags_q                    architectural flag register {N,Z,C,V}

module alu_result_stage #(
   parameter int WIDTH = 32,
   parameter int RD_W  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic [3:0]       in_flags,
   input  logic             in_set_flags,
   input  logic [3:0]       in_cond,
   input  logic [RD_W-1:0]  in_rd,
   input  logic             in_wr_en,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [RD_W-1:0]  out_rd,
   output logic             out_wr_en,
   output logic [3:0]       flags_q
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic [3:0]       flags_d;

   logic [WIDTH-1:0] main_result_q, main_result_d;
   logic [RD_W-1:0]  main_rd_q, main_rd_d;
   logic             main_wr_en_q, main_wr_en_d;

   logic [WIDTH-1:0] skid_result_q, skid_result_d;
   logic [RD_W-1:0]  skid_rd_q, skid_rd_d;
   logic             skid_wr_en_q, skid_wr_en_d;

   logic             cond_pass;
   logic             accept;
   logic             xfer;
   logic             new_wr_en;
   logic             f_n, f_z, f_c, f_v;

   assign {f_n, f_z, f_c, f_v} = flags_q;

   // Condition is judged against the flags held before this edge, so an
   // entry never sees its own flag update.
   always_comb begin
      cond_pass = 1'b0;
      case (in_cond)
         4'h0: cond_pass = f_z;
         4'h1: cond_pass = !f_z;
         4'h2: cond_pass = f_c;
         4'h3: cond_pass = !f_c;
         4'h4: cond_pass = f_n;
         4'h5: cond_pass = !f_n;
         4'h6: cond_pass = f_v;
         4'h7: cond_pass = !f_v;
         4'h8: cond_pass = f_c && !f_z;
         4'h9: cond_pass = !f_c || f_z;
         4'hA: cond_pass = (f_n == f_v);
         4'hB: cond_pass = (f_n != f_v);
         4'hC: cond_pass = !f_z && (f_n == f_v);
         4'hD: cond_pass = f_z || (f_n != f_v);
         4'hE: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   assign out_valid = (state_q != ST_EMPTY);
   assign in_ready  = in_ready_q;
   assign accept    = in_valid && in_ready_q && !flush;
   assign xfer      = out_valid && out_ready;
   // A failed condition still occupies a slot but must not write rd.
   assign new_wr_en = in_wr_en && cond_pass;

   always_comb begin
      state_d       = state_q;
      main_result_d = main_result_q;
      main_rd_d     = main_rd_q;
      main_wr_en_d  = main_wr_en_q;
      skid_result_d = skid_result_q;
      skid_rd_d     = skid_rd_q;
      skid_wr_en_d  = skid_wr_en_q;
      flags_d       = flags_q;

      if (accept && cond_pass && in_set_flags) begin
         flags_d = in_flags;
      end

      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_result_d = in_result;
               main_rd_d     = in_rd;
               main_wr_en_d  = new_wr_en;
               state_d       = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && xfer) begin
               main_result_d = in_result;
               main_rd_d     = in_rd;
               main_wr_en_d  = new_wr_en;
            end else if (accept) begin
               skid_result_d = in_result;
               skid_rd_d     = in_rd;
               skid_wr_en_d  = new_wr_en;
               state_d       = ST_FULL;
            end else if (xfer) begin
               state_d       = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // in_ready is low here, so only the drain path exists.
            if (xfer) begin
               main_result_d = skid_result_q;
               main_rd_d     = skid_rd_q;
               main_wr_en_d  = skid_wr_en_q;
               state_d       = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      // Flush empties the buffer; flags keep whatever was committed.
      if (flush) begin
         state_d = ST_EMPTY;
      end

      // Registered ready: low exactly when the skid slot will be occupied.
      in_ready_d = (state_d != ST_FULL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_EMPTY;
         in_ready_q    <= 1'b1;
         flags_q       <= 4'b0000;
         main_result_q <= '0;
         main_rd_q     <= '0;
         main_wr_en_q  <= 1'b0;
         skid_result_q <= '0;
         skid_rd_q     <= '0;
         skid_wr_en_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         in_ready_q    <= in_ready_d;
         flags_q       <= flags_d;
         main_result_q <= main_result_d;
         main_rd_q     <= main_rd_d;
         main_wr_en_q  <= main_wr_en_d;
         skid_result_q <= skid_result_d;
         skid_rd_q     <= skid_rd_d;
         skid_wr_en_q  <= skid_wr_en_d;
      end
   end

   // Payload is masked so a stale main register never leaks downstream.
   assign out_result = out_valid ? main_result_q : '0;
   assign out_rd     = out_valid ? main_rd_q : '0;
   assign out_wr_en  = out_valid && main_wr_en_q;

endmodule
